pipe_regfile_sb: RTL and testbench
==================================

Name: pipe_regfile_sb

Overview:
- Parametrised successor to the pipeline CPU's 32x32 register file.
- Adds N combinational read ports, write-first bypass, hardwired-zero register 0, and a per-register scoreboard of pending writes.
- The scoreboard lets the ID stage detect RAW hazards against in-flight producers.
- Sits between ID (reads, reservations) and WB (writeback).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of read ports (>=1).
- BYPASS, 1, 1 = same-cycle writeback is forwarded to reads; 0 = reads see the array only.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i uses slice [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data, same packing as rd_addr.
- rd_busy  out  NUM_RD  1 = the addressed register has an outstanding reservation.
- we  in  1  writeback enable.
- wa  in  ADDR_W  writeback address.
- wd  in  DATA_W  writeback data.
- rsv_en  in  1  reserve the destination register of an instruction issuing this cycle.
- rsv_addr  in  ADDR_W  register to reserve.
- busy_cnt  out  ADDR_W+1  number of registers currently reserved.
- any_busy  out  1  busy_cnt != 0.

Behaviour:
- Reset: while rst is low, asynchronously and immediately:
  - every register reads 0;
  - all busy bits clear;
  - busy_cnt = 0, any_busy = 0.
  - Assertion mid-operation discards pending writes and reservations.
- Write: at posedge clk, if we=1 and wa!=0, reg[wa] <= wd. Writes to address 0 are ignored.
- Read data (combinational, zero latency):
  - rd_data[i] = 0 if rd_addr[i]==0;
  - else wd if BYPASS=1 and we=1 and wa==rd_addr[i];
  - else reg[rd_addr[i]].
- Read busy:
  - rd_busy[i] = busy[rd_addr[i]], masked to 0 when BYPASS=1 and we=1 and wa==rd_addr[i] (value is being delivered this cycle).
  - Register 0 is never busy.
- Scoreboard update at posedge clk:
  - rsv_en=1 and rsv_addr!=0 sets busy[rsv_addr].
  - we=1 and wa!=0 clears busy[wa].
  - Same address in the same cycle: the set wins (a newer producer supersedes the retiring one).
  - Reserving an already-busy register leaves it busy; busy_cnt is unchanged.
  - Writeback to a non-busy register is legal; it writes data and leaves busy at 0.
- busy_cnt is registered and always equals the popcount of the busy bits (range 0..2**ADDR_W-1).
  - Per-cycle update: +1 for a 0->1 transition, -1 for a 1->0 transition.
  - Set and clear on different registers in the same cycle: net 0.
- Any number of read ports may address the same register; all get identical results.

Optional Feature:
- Macro: REGFILE_DBG_EN.
- Defined: adds ports dbg_addr (in, ADDR_W) and dbg_data (out, DATA_W).
  - dbg_data = reg[dbg_addr], raw array contents, no bypass; 0 for address 0.
  - Adds dbg_busy (out, 2**ADDR_W), the full scoreboard vector, for testbench and debug-board probing.
- Undefined: these ports do not exist and no related logic is generated.

Decomposition:
- Shared package regfile_pkg holds:
  - defaults DATA_W_DEF=32, ADDR_W_DEF=5, NUM_RD_DEF=2;
  - the constant REG_ZERO=0.
- One sub-module, regfile_scoreboard, holds the busy vector, the set/clear priority and busy_cnt.
- The top level holds the data array, read muxes and bypass.

Test Plan:
- Reset: drive rst=0 mid-run after writing r5=0xDEADBEEF -> rd_data for r5 reads 0 immediately; busy_cnt=0; any_busy=0.
- Basic write/read: we=1, wa=3, wd=0x12345678, then we=0 -> next cycle both read ports at addr 3 return 0x12345678.
- Zero register: we=1, wa=0, wd=0xFFFFFFFF; rsv_en=1, rsv_addr=0 -> rd_data at addr 0 = 0, rd_busy=0, busy_cnt stays 0.
- Bypass: reg[7]=0x1; same cycle we=1, wa=7, wd=0xABCD with rd_addr0=7 -> rd_data0=0xABCD and rd_busy0=0 in that cycle.
  - With BYPASS=0 the same stimulus gives rd_data0=0x1.
- Scoreboard:
  - reserve 4, then 9 -> busy_cnt=2; rd_busy for addr 4 = 1.
  - writeback 4 -> busy_cnt=1.
  - rsv 9 and we 9 in the same cycle -> busy[9] stays 1, busy_cnt=1.
- Count saturation: reserve all 31 non-zero registers over 31 cycles -> busy_cnt=31; release them all -> busy_cnt=0, any_busy=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared constants for the pipelined register file with scoreboard.
//   DATA_W_DEF / ADDR_W_DEF / NUM_RD_DEF : default parameter values
//   REG_ZERO                             : index of the hardwired-zero register
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_RD_DEF = 2;
    localparam int REG_ZERO   = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
// Per-register pending-write (busy) bits plus a registered popcount.
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_set_en, i_set_addr  reserve a destination register (issue)
//   i_clr_en, i_clr_addr  retire a destination register (writeback)
//   o_busy                full busy vector (bit 0 is never set)
//   o_cnt                 number of busy registers
// ---------------------------------------------------------------------------
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_set_en,
    input  logic [ADDR_W-1:0]      i_set_addr,
    input  logic                   i_clr_en,
    input  logic [ADDR_W-1:0]      i_clr_addr,
    output logic [(2**ADDR_W)-1:0] o_busy,
    output logic [ADDR_W:0]        o_cnt
);

    localparam int                DEPTH  = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

    logic [DEPTH-1:0] r_busy;
    logic [ADDR_W:0]  r_cnt;

    logic             w_set;
    logic             w_clr;
    logic             w_inc;
    logic             w_dec;
    logic [DEPTH-1:0] w_busy_nxt;
    logic [ADDR_W:0]  w_cnt_nxt;

    // A reservation and a writeback on the same register: the newer
    // producer wins, so the clear is suppressed entirely.
    assign w_set = i_set_en && (i_set_addr != ZERO_A);
    assign w_clr = i_clr_en && (i_clr_addr != ZERO_A) &&
                   !(w_set && (i_set_addr == i_clr_addr));

    // Count only real transitions so re-reserving a busy register or
    // retiring an idle one leaves the count untouched.
    assign w_inc = w_set && !r_busy[i_set_addr];
    assign w_dec = w_clr &&  r_busy[i_clr_addr];

    always_comb begin
        w_busy_nxt = r_busy;
        if (w_clr) w_busy_nxt[i_clr_addr] = 1'b0;
        if (w_set) w_busy_nxt[i_set_addr] = 1'b1;
    end

    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({w_inc, w_dec})
            2'b10:   w_cnt_nxt = r_cnt + (ADDR_W+1)'(1);
            2'b01:   w_cnt_nxt = r_cnt - (ADDR_W+1)'(1);
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign o_busy = r_busy;
    assign o_cnt  = r_cnt;

endmodule

// File: rtl/pipe_regfile_sb.sv
// ---------------------------------------------------------------------------
// pipe_regfile_sb
// Parametrised register file: NUM_RD combinational read ports, optional
// write-first bypass, hardwired-zero register 0 and a pending-write
// scoreboard for RAW hazard detection in ID.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   rd_addr / rd_data   packed read ports, port i at slice i
//   rd_busy             per-port: addressed register has a pending write
//   we, wa, wd          writeback
//   rsv_en, rsv_addr    reserve destination of an issuing instruction
//   busy_cnt, any_busy  scoreboard occupancy
// Optional (macro REGFILE_DBG_EN):
//   dbg_addr / dbg_data raw array read, no bypass
//   dbg_busy            full scoreboard vector
// ---------------------------------------------------------------------------
module pipe_regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = NUM_RD_DEF,
    parameter int BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [DATA_W-1:0]        wd,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic [ADDR_W:0]          busy_cnt,
    output logic                     any_busy
`ifdef REGFILE_DBG_EN
   ,input  logic [ADDR_W-1:0]        dbg_addr,
    output logic [DATA_W-1:0]        dbg_data,
    output logic [(2**ADDR_W)-1:0]   dbg_busy
`endif
);

    localparam int                DEPTH  = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);
    localparam bit                BYP_EN = (BYPASS != 0);

    logic [DATA_W-1:0]             r_mem [DEPTH];
    logic                          w_wr;
    logic [DEPTH-1:0]              w_busy;
    logic [NUM_RD-1:0][ADDR_W-1:0] w_ra;
    logic [NUM_RD-1:0]             w_byp;

    assign w_wr = we && (wa != ZERO_A);

    // Entry 0 is cleared on reset and never written, so it stays zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_wr) begin
            r_mem[wa] <= wd;
        end
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_sb (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_set_en   (rsv_en),
        .i_set_addr (rsv_addr),
        .i_clr_en   (we),
        .i_clr_addr (wa),
        .o_busy     (w_busy),
        .o_cnt      (busy_cnt)
    );

    assign any_busy = (busy_cnt != '0);

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        assign w_ra[g] = rd_addr[g*ADDR_W +: ADDR_W];
        // Bypass is gated by rst so every register reads 0 during reset.
        assign w_byp[g] = BYP_EN && rst && w_wr && (wa == w_ra[g]);

        assign rd_data[g*DATA_W +: DATA_W] =
            (w_ra[g] == ZERO_A) ? '0 :
            w_byp[g]            ? wd : r_mem[w_ra[g]];

        // A register whose value is being forwarded this cycle is no
        // longer a hazard for the reader.
        assign rd_busy[g] = w_busy[w_ra[g]] && !w_byp[g] && (w_ra[g] != ZERO_A);
    end

`ifdef REGFILE_DBG_EN
    assign dbg_data = (dbg_addr == ZERO_A) ? '0 : r_mem[dbg_addr];
    assign dbg_busy = w_busy;
`endif

endmodule

// File: tb/tb_pipe_regfile_sb.sv
module tb_pipe_regfile_sb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  rd_addr = '0;
    logic [63:0] rd_data, rd_data_nb;
    logic [1:0]  rd_busy, rd_busy_nb;
    logic        we = 1'b0;
    logic [4:0]  wa = '0;
    logic [31:0] wd = '0;
    logic        rsv_en = 1'b0;
    logic [4:0]  rsv_addr = '0;
    logic [5:0]  busy_cnt, busy_cnt_nb;
    logic        any_busy, any_busy_nb;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        string       name;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  bsy;
        logic [5:0]  cnt;
        logic        anyb;
        logic [31:0] nb_d0;
        logic [1:0]  nb_bsy;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    pipe_regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1)) u_dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .we(we), .wa(wa), .wd(wd), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .busy_cnt(busy_cnt), .any_busy(any_busy)
    );

    pipe_regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0)) u_nb (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
        .we(we), .wa(wa), .wd(wd), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .busy_cnt(busy_cnt_nb), .any_busy(any_busy_nb)
    );

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
        end
    endtask

    // Monitor: outputs are combinational, sampled mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.name, "d0",      rd_data[31:0],          e.d0);
            chk(e.name, "d1",      rd_data[63:32],         e.d1);
            chk(e.name, "busy",    32'(rd_busy),           32'(e.bsy));
            chk(e.name, "cnt",     32'(busy_cnt),          32'(e.cnt));
            chk(e.name, "any",     32'(any_busy),          32'(e.anyb));
            chk(e.name, "nb_d0",   rd_data_nb[31:0],       e.nb_d0);
            chk(e.name, "nb_busy", 32'(rd_busy_nb),        32'(e.nb_bsy));
            chk(e.name, "nb_cnt",  32'(busy_cnt_nb),       32'(e.cnt));
            chk(e.name, "nb_any",  32'(any_busy_nb),       32'(e.anyb));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic iwe, input logic [4:0] iwa, input logic [31:0] iwd,
                       input logic irs, input logic [4:0] ira,
                       input logic [4:0] a0, input logic [4:0] a1);
        we = iwe; wa = iwa; wd = iwd;
        rsv_en = irs; rsv_addr = ira;
        rd_addr = {a1, a0};
    endtask

    task automatic expect_out(input string nm, input logic [31:0] d0, input logic [31:0] d1,
                              input logic [1:0] bsy, input logic [5:0] cnt, input logic anyb,
                              input logic [31:0] nbd0, input logic [1:0] nbbsy);
        exp_t e;
        e.name = nm; e.d0 = d0; e.d1 = d1; e.bsy = bsy; e.cnt = cnt;
        e.anyb = anyb; e.nb_d0 = nbd0; e.nb_bsy = nbbsy;
        q.push_back(e);
    endtask

    initial begin
        drv(0, 0, 0, 0, 0, 0, 0);
        #1;
        expect_out("reset", 0, 0, 2'b00, 0, 0, 0, 2'b00);
        cyc(); cyc();
        rst = 1'b1;

        // write r5, reserve r6, then pull reset mid-run
        cyc(); drv(1, 5, 32'hDEADBEEF, 0, 0, 5, 0);
        expect_out("byp5", 32'hDEADBEEF, 0, 2'b00, 0, 0, 0, 2'b00);
        cyc(); drv(0, 0, 0, 1, 6, 5, 5);
        expect_out("wr5", 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0, 0, 32'hDEADBEEF, 2'b00);
        cyc(); drv(0, 0, 0, 0, 0, 6, 5);
        expect_out("pre_rst", 0, 32'hDEADBEEF, 2'b01, 1, 1, 0, 2'b01);
        cyc(); rst = 1'b0; drv(0, 0, 0, 0, 0, 5, 6);
        expect_out("rst_mid", 0, 0, 2'b00, 0, 0, 0, 2'b00);
        cyc(); rst = 1'b1; drv(0, 0, 0, 0, 0, 5, 6);
        expect_out("rst_after", 0, 0, 2'b00, 0, 0, 0, 2'b00);

        // basic write/read
        cyc(); drv(1, 3, 32'h12345678, 0, 0, 0, 0);
        cyc(); drv(0, 0, 0, 0, 0, 3, 3);
        expect_out("rw3", 32'h12345678, 32'h12345678, 2'b00, 0, 0, 32'h12345678, 2'b00);

        // register zero
        cyc(); drv(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0);
        expect_out("zero_w", 0, 0, 2'b00, 0, 0, 0, 2'b00);
        cyc(); drv(0, 0, 0, 0, 0, 0, 0);
        expect_out("zero_after", 0, 0, 2'b00, 0, 0, 0, 2'b00);

        // bypass: r7=1, reserve r7, then writeback 0xABCD while reading it
        cyc(); drv(1, 7, 32'h1, 0, 0, 0, 0);
        cyc(); drv(0, 0, 0, 1, 7, 0, 0);
        cyc(); drv(1, 7, 32'hABCD, 0, 0, 7, 3);
        expect_out("bypass", 32'hABCD, 32'h12345678, 2'b00, 1, 1, 32'h1, 2'b01);
        cyc(); drv(0, 0, 0, 0, 0, 7, 7);
        expect_out("byp_after", 32'hABCD, 32'hABCD, 2'b00, 0, 0, 32'hABCD, 2'b00);

        // scoreboard
        cyc(); drv(0, 0, 0, 1, 4, 4, 9);
        expect_out("rsv4", 0, 0, 2'b00, 0, 0, 0, 2'b00);
        cyc(); drv(0, 0, 0, 1, 9, 4, 9);
        expect_out("rsv9", 0, 0, 2'b01, 1, 1, 0, 2'b01);
        cyc(); drv(0, 0, 0, 0, 0, 4, 9);
        expect_out("busy2", 0, 0, 2'b11, 2, 1, 0, 2'b11);
        cyc(); drv(1, 4, 32'h44, 0, 0, 4, 9);
        expect_out("wb4", 32'h44, 0, 2'b10, 2, 1, 0, 2'b11);
        cyc(); drv(1, 9, 32'h99, 1, 9, 4, 9);
        expect_out("same9", 32'h44, 32'h99, 2'b00, 1, 1, 32'h44, 2'b10);
        cyc(); drv(0, 0, 0, 0, 0, 9, 4);
        expect_out("same9_after", 32'h99, 32'h44, 2'b01, 1, 1, 32'h99, 2'b01);

        // set r10 and clear r9 in the same cycle: net zero
        cyc(); drv(1, 9, 32'h5, 1, 10, 9, 10);
        expect_out("swap", 32'h5, 0, 2'b00, 1, 1, 32'h99, 2'b01);
        cyc(); drv(0, 0, 0, 0, 0, 9, 10);
        expect_out("swap_after", 32'h5, 0, 2'b10, 1, 1, 32'h5, 2'b10);

        // reserve every non-zero register (r10 already busy)
        for (int i = 1; i < 32; i++) begin
            cyc(); drv(0, 0, 0, 1, 5'(i), 0, 0);
        end
        cyc(); drv(0, 0, 0, 0, 0, 31, 1);
        expect_out("sat31", 0, 0, 2'b11, 31, 1, 0, 2'b11);

        // release them all, writing each register's own index
        for (int i = 1; i < 32; i++) begin
            cyc(); drv(1, 5'(i), 32'(i), 0, 0, 0, 0);
        end
        cyc(); drv(0, 0, 0, 0, 0, 31, 1);
        expect_out("rel_all", 32'd31, 32'd1, 2'b00, 0, 0, 32'd31, 2'b00);

        begin
            int budget;
            budget = 0;
            while (q.size() != 0 && budget < 20) begin
                @(posedge clk);
                budget++;
            end
            if (q.size() != 0) begin
                n_err++;
                $display("FAIL drain: %0d expectations left, required 0", q.size());
            end
        end
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
